// File: rtl/key_event_arbiter_pkg.sv
// key_event_arbiter_pkg
//   Shared definitions for the key event arbiter: event type encodings,
//   output-stage state codes and the key index width helper.
//   No ports (package).
//   Optional feature macro used by the importing modules: KEY_EVENT_RELEASE_EN.
package key_event_arbiter_pkg;

    // Event type carried in the release bit of a queued entry.
    localparam logic EVT_PRESS   = 1'b0;
    localparam logic EVT_RELEASE = 1'b1;

    // Output register state.
    localparam int STATE_W = 1;
    typedef enum logic [STATE_W-1:0] {
        OUT_EMPTY = 1'b0,
        OUT_VALID = 1'b1
    } out_state_t;

    // Width of a key index; never narrower than one bit.
    function automatic int key_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo
//   Synchronous FIFO holding granted key events ahead of the output register.
//   Push into a full FIFO and pop from an empty FIFO are ignored.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous reset, active high (high = reset)
//   push   in   write din this cycle
//   din    in   entry to write
//   pop    in   remove head this cycle
//   dout   out  current head entry (valid when empty = 0)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  number of entries held
module key_event_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage carries no reset: only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// key_event_arbiter
//   Latches single-cycle press (and optionally release) pulses per key,
//   grants one pending key per cycle round-robin into a small FIFO, and
//   presents the queued events as a valid/ack stream through an output
//   register.
//   Macro KEY_EVENT_RELEASE_EN: when defined, release pulses are tracked and
//   reported with evt_release = 1; otherwise key_off is ignored and
//   evt_release is tied to 0.
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous reset, active high (high = reset)
//   key_on        in   per-key press pulse
//   key_off       in   per-key release pulse
//   evt_ack       in   consumer accepts the presented event
//   clr_overflow  in   clear the sticky overflow flag
//   evt_valid     out  event present on evt_code/evt_release
//   evt_code      out  index of the key that produced the event
//   evt_release   out  0 = press, 1 = release
//   overflow      out  sticky: at least one event was dropped
//   fifo_count    out  entries held in the FIFO (output register excluded)
module key_event_arbiter
    import key_event_arbiter_pkg::*;
#(
    parameter int NUM_KEYS   = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int KEY_IDX_W = key_idx_w(NUM_KEYS),
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_KEYS-1:0]  key_on,
    input  logic [NUM_KEYS-1:0]  key_off,
    input  logic                 evt_ack,
    input  logic                 clr_overflow,
    output logic                 evt_valid,
    output logic [KEY_IDX_W-1:0] evt_code,
    output logic                 evt_release,
    output logic                 overflow,
    output logic [CNT_W-1:0]     fifo_count
);

`ifdef KEY_EVENT_RELEASE_EN
    localparam int ENTRY_W = KEY_IDX_W + 1;
`else
    localparam int ENTRY_W = KEY_IDX_W;
`endif

    logic [NUM_KEYS-1:0]  pend_on;
    logic [NUM_KEYS-1:0]  req;
    logic [NUM_KEYS-1:0]  grant_mask;
    logic [NUM_KEYS-1:0]  clr_on;
    logic [KEY_IDX_W-1:0] rr_ptr;
    logic [KEY_IDX_W-1:0] grant_idx;
    logic                 grant_valid;
    logic                 drop;
    logic [ENTRY_W-1:0]   fifo_din;
    logic [ENTRY_W-1:0]   fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    out_state_t           state;
    out_state_t           state_next;

    // Index base+k reduced modulo NUM_KEYS (k < NUM_KEYS, base < NUM_KEYS).
    function automatic logic [KEY_IDX_W-1:0] wrap_idx(input logic [KEY_IDX_W-1:0] base,
                                                      input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_KEYS) begin
            s = s - NUM_KEYS;
        end
        return KEY_IDX_W'(s);
    endfunction

    // Round-robin search starting at rr_ptr; no grant while the FIFO is full.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (!fifo_full) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (!grant_valid && req[wrap_idx(rr_ptr, k)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = wrap_idx(rr_ptr, k);
                end
            end
        end
    end

    assign grant_mask = grant_valid ? (NUM_KEYS'(1) << grant_idx) : '0;

`ifdef KEY_EVENT_RELEASE_EN
    logic [NUM_KEYS-1:0] pend_off;
    logic [NUM_KEYS-1:0] clr_off;
    logic                grant_rel;

    // A key with both bits pending reports its press first.
    assign grant_rel = pend_on[grant_idx] ? EVT_PRESS : EVT_RELEASE;
    assign req       = pend_on | pend_off;
    assign clr_on    = (grant_rel == EVT_PRESS)   ? grant_mask : '0;
    assign clr_off   = (grant_rel == EVT_RELEASE) ? grant_mask : '0;
    assign drop      = (|(key_on & pend_on & ~clr_on)) | (|(key_off & pend_off & ~clr_off));
    assign fifo_din  = {grant_idx, grant_rel};

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pend_off <= '0;
        end else begin
            pend_off <= (pend_off & ~clr_off) | key_off;
        end
    end
`else
    logic key_off_unused;

    assign key_off_unused = ^key_off;
    assign req            = pend_on;
    assign clr_on         = grant_mask;
    assign drop           = |(key_on & pend_on & ~clr_on);
    assign fifo_din       = grant_idx;
    assign evt_release    = EVT_PRESS;
`endif

    // Pending latch, round-robin pointer and sticky overflow. A new pulse
    // on the key being granted re-arms the bit instead of being dropped.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pend_on  <= '0;
            rr_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            pend_on <= (pend_on & ~clr_on) | key_on;
            if (grant_valid) begin
                rr_ptr <= (int'(grant_idx) == NUM_KEYS - 1) ? '0 : grant_idx + KEY_IDX_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    key_event_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant_valid),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Output stage state register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Refill the output register whenever it is empty or being acknowledged.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            OUT_EMPTY: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = OUT_VALID;
                end
            end
            OUT_VALID: begin
                if (evt_ack) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_next = OUT_EMPTY;
                    end
                end
            end
            default: state_next = OUT_EMPTY;
        endcase
    end

    assign evt_valid = (state == OUT_VALID);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            evt_code <= '0;
`ifdef KEY_EVENT_RELEASE_EN
            evt_release <= EVT_PRESS;
`endif
        end else if (fifo_pop) begin
`ifdef KEY_EVENT_RELEASE_EN
            {evt_code, evt_release} <= fifo_dout;
`else
            evt_code <= fifo_dout;
`endif
        end
    end

endmodule

// File: tb/tb_key_event_arbiter.sv
// tb_key_event_arbiter
//   Self-checking bench for key_event_arbiter (NUM_KEYS = 8, FIFO_DEPTH = 4).
//   Table-driven vectors, hand-written corner sequences and random traffic
//   checked against an event-queue reference model.
//   Honours KEY_EVENT_RELEASE_EN the same way as the design.
module tb_key_event_arbiter;

    localparam int N = 8;
    localparam int D = 4;
`ifdef KEY_EVENT_RELEASE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] key_on = '0;
    logic [N-1:0] key_off = '0;
    logic         evt_ack = 1'b0;
    logic         clr_overflow = 1'b0;
    logic         evt_valid;
    logic [2:0]   evt_code;
    logic         evt_release;
    logic         overflow;
    logic [2:0]   fifo_count;

    int checks = 0;
    int errors = 0;

    key_event_arbiter #(.NUM_KEYS(N), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_on       (key_on),
        .key_off      (key_off),
        .evt_ack      (evt_ack),
        .clr_overflow (clr_overflow),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_release  (evt_release),
        .overflow     (overflow),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: pending flags per key, FIFO as a queue of
    // (code*2 + release) entries, plus the single output slot.
    bit m_pon[N];
    bit m_poff[N];
    int m_rr;
    int m_q[$];
    bit m_valid;
    int m_code;
    bit m_rel;
    bit m_ovf;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_pon[i]  = 1'b0;
            m_poff[i] = 1'b0;
        end
        m_rr = 0;
        m_q.delete();
        m_valid = 1'b0;
        m_code  = 0;
        m_rel   = 1'b0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void model_step(input logic [N-1:0] on, input logic [N-1:0] off,
                                       input bit ack, input bit clr);
        int  g = -1;
        bit  grel = 1'b0;
        bit  drop = 1'b0;
        int  e;
        if (m_q.size() < D) begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_rr + k) % N;
                if (g < 0 && (m_pon[idx] || m_poff[idx])) g = idx;
            end
        end
        if (!m_valid || ack) begin
            if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_valid = 1'b1;
                m_code  = e / 2;
                m_rel   = (e % 2) == 1;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (g >= 0) begin
            grel = !m_pon[g];
            if (grel) m_poff[g] = 1'b0;
            else      m_pon[g]  = 1'b0;
            m_q.push_back(g * 2 + int'(grel));
            m_rr = (g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (on[i]) begin
                if (m_pon[i]) drop = 1'b1;
                m_pon[i] = 1'b1;
            end
            if (REL_EN && off[i]) begin
                if (m_poff[i]) drop = 1'b1;
                m_poff[i] = 1'b1;
            end
        end
        if (drop)     m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endfunction

    task automatic cycle(input logic [N-1:0] on, input logic [N-1:0] off,
                         input bit ack, input bit clr);
        key_on       = on;
        key_off      = off;
        evt_ack      = ack;
        clr_overflow = clr;
        @(posedge clk);
        model_step(on, off, ack, clr);
        #1;
        check("valid", evt_valid, m_valid);
        if (m_valid) begin
            check("code", evt_code, m_code);
            check("release", evt_release, m_rel);
        end
        check("overflow", overflow, m_ovf);
        check("fifo_count", fifo_count, m_q.size());
    endtask

    task automatic do_reset();
        key_on = '0; key_off = '0; evt_ack = 1'b0; clr_overflow = 1'b0;
        rst_n = 1'b1;
        model_reset();
        #1;
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_release", evt_release, 0);
        check("rst_overflow", overflow, 0);
        check("rst_count", fifo_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    typedef struct {
        bit           rst_first;
        logic [N-1:0] on;
        bit           ack;
        bit           ev;
        int           code;
        int           cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit r, input logic [N-1:0] on, input bit ack,
                                input bit ev, input int code, input int cnt);
        vec_t v;
        v.rst_first = r; v.on = on; v.ack = ack; v.ev = ev; v.code = code; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int codes[$];
        logic [N-1:0] r_on;
        logic [N-1:0] r_off;

        // Single press on key 3 with ack held high.
        add(1, 8'h08, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 1);
        add(0, 8'h00, 1, 1, 3, 0);
        add(0, 8'h00, 1, 0, 0, 0);
        // All keys pressed at once: codes 0..7 back to back.
        add(1, 8'hFF, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 1);
        for (int k = 2; k <= 8; k++) add(0, 8'h00, 1, 1, k - 2, 1);
        add(0, 8'h00, 1, 1, 7, 0);
        add(0, 8'h00, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_first) do_reset();
            cycle(vecs[i].on, '0, vecs[i].ack, 1'b0);
            check("tbl_valid", evt_valid, vecs[i].ev);
            if (vecs[i].ev) check("tbl_code", evt_code, vecs[i].code);
            check("tbl_count", fifo_count, vecs[i].cnt);
            check("tbl_overflow", overflow, 0);
        end

        // Press then release on key 5 with the consumer stalled.
        do_reset();
        cycle(8'h20, 8'h00, 0, 0);
        cycle(8'h00, 8'h20, 0, 0);
        cycle(8'h00, 8'h00, 0, 0);
        cycle(8'h00, 8'h00, 0, 0);
        check("pr_first_valid", evt_valid, 1);
        check("pr_first_code", evt_code, 5);
        check("pr_first_rel", evt_release, 0);
        check("pr_count", fifo_count, REL_EN ? 1 : 0);
        cycle(8'h00, 8'h00, 1, 0);
        check("pr_second_valid", evt_valid, REL_EN ? 1 : 0);
        if (REL_EN) begin
            check("pr_second_code", evt_code, 5);
            check("pr_second_rel", evt_release, 1);
        end
        cycle(8'h00, 8'h00, 1, 0);
        check("pr_done", evt_valid, 0);

        // Six presses with the consumer stalled: FIFO fills, one stays pending.
        do_reset();
        cycle(8'h3F, 8'h00, 0, 0);
        for (int k = 0; k < 6; k++) cycle('0, '0, 0, 0);
        check("full_count", fifo_count, 4);
        check("full_valid", evt_valid, 1);
        check("full_code", evt_code, 0);
        check("full_ovf", overflow, 0);
        cycle(8'h20, 8'h00, 0, 0);
        check("drop_ovf", overflow, 1);
        cycle(8'h00, 8'h00, 0, 1);
        check("clr_ovf", overflow, 0);
        cycle(8'h20, 8'h00, 0, 1);
        check("drop_beats_clr", overflow, 1);
        cycle(8'h00, 8'h00, 0, 1);
        check("clr_ovf2", overflow, 0);
        for (int k = 0; k < 10; k++) cycle('0, '0, 1, 0);
        check("drain_valid", evt_valid, 0);
        check("drain_count", fifo_count, 0);

        // Round-robin fairness between keys 1 and 6.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            cycle(8'h42, 8'h00, 1, 0);
            if (evt_valid) codes.push_back(int'(evt_code));
        end
        check("rr_first", codes[0], 1);
        for (int k = 1; k < codes.size(); k++) begin
            check("rr_alternate", codes[k], (codes[k - 1] == 1) ? 6 : 1);
        end
        for (int k = 0; k < 6; k++) cycle('0, '0, 1, 1);

        // Reset with several events queued and one presented.
        do_reset();
        cycle(8'h0F, 8'h00, 0, 0);
        for (int k = 0; k < 4; k++) cycle('0, '0, 0, 0);
        check("pre_rst_valid", evt_valid, 1);
        check("pre_rst_count", fifo_count, 3);
        do_reset();
        for (int k = 0; k < 5; k++) cycle('0, '0, 1, 0);
        check("post_rst_valid", evt_valid, 0);

        // Random traffic against the model, with stall bursts and one reset.
        for (int k = 0; k < 600; k++) begin
            if (k == 300) do_reset();
            r_on  = N'($urandom & $urandom & $urandom);
            r_off = N'($urandom & $urandom & $urandom);
            cycle(r_on, r_off, ((k / 40) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
